// File: rtl/uart_rx_16x.sv
// 16x-oversampled UART receiver: start, DATA_BITS data bits (LSB first), optional even parity, stop.
// Define UART_RX_PARITY_EN to add the even-parity bit and the rx_parity_err pulse.
module uart_rx_16x #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_busy
);

   localparam int unsigned CntW = $clog2(OVERSAMPLE);
   localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
   localparam logic [2:0] BitLast = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [2:0]           bitn_q, bitn_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 rx_meta_q, rx_s_q;
   logic                 parity_ok;
`ifdef UART_RX_PARITY_EN
   logic                 par_q, par_d;
   logic                 perr_q, perr_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= StIdle;
         cnt_q     <= '0;
         bitn_q    <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bitn_q    <= bitn_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q     <= par_d;
         perr_q    <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bitn_d  = bitn_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d     = par_q;
      perr_d    = 1'b0;
      // Even parity: data ones plus the parity bit must total an even count.
      parity_ok = ~(^shift_q ^ par_q);
`else
      parity_ok = 1'b1;
`endif
      if (rx_tick) begin
         cnt_d = cnt_q + CntW'(1);
         unique case (state_q)
            StIdle: begin
               cnt_d = '0;
               if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
               if (cnt_q == CntHalf) begin
                  cnt_d   = '0;
                  bitn_d  = '0;
                  state_d = rx_s_q ? StIdle : StData;
               end
            end
            StData: begin
               if (cnt_q == CntLast) begin
                  shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                  bitn_d  = bitn_q + 3'd1;
                  if (bitn_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                     state_d = StParity;
`else
                     state_d = StStop;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
               if (cnt_q == CntLast) begin
                  par_d   = rx_s_q;
                  state_d = StStop;
               end
            end
`endif
            StStop: begin
               // Leave at mid stop bit so a back-to-back start edge is not missed.
               if (cnt_q == CntLast) begin
                  state_d = StIdle;
                  if (!rx_s_q) begin
                     ferr_d = 1'b1;
                  end else if (parity_ok) begin
                     valid_d = 1'b1;
                     data_d  = shift_q;
                  end else begin
`ifdef UART_RX_PARITY_EN
                     perr_d = 1'b1;
`endif
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
   assign rx_parity_err = perr_q;
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: good frames, false start, framing error, back-to-back,
// mid-frame reset, slow tick and (with UART_RX_PARITY_EN) parity error.
module tb_uart_rx_16x;

   localparam int unsigned Os = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_parity_err;
   logic       rx_busy;

   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;
   int n_ferr  = 0;
   int n_perr  = 0;
   int n_multi = 0;
   int exp_valid = 0;
   int exp_ferr  = 0;
   int exp_perr  = 0;
   int tick_period = 1;
   int tick_cnt    = 0;

   uart_rx_16x #(
      .DATA_BITS (8),
      .OVERSAMPLE(Os)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_tick      (rx_tick),
      .rx           (rx),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
      .rx_parity_err(rx_parity_err),
      .rx_busy      (rx_busy)
   );

   always #5 clk = ~clk;

   // Tick generator: one pulse every tick_period cycles.
   initial begin
      rx_tick = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tick_cnt = (tick_cnt + 1 >= tick_period) ? 0 : tick_cnt + 1;
         rx_tick  = (tick_cnt == 0);
      end
   end

   // Pulse counters sampled on the falling edge; a stretched pulse counts twice.
   always @(negedge clk) begin
      if (rx_valid)      n_valid <= n_valid + 1;
      if (rx_frame_err)  n_ferr  <= n_ferr + 1;
      if (rx_parity_err) n_perr  <= n_perr + 1;
      if (int'(rx_valid) + int'(rx_frame_err) + int'(rx_parity_err) > 1) n_multi <= n_multi + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      cycles(Os * tick_period);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                             input logic chk_busy);
      send_bit(1'b0);
      if (chk_busy) check("busy_mid_frame", 32'(rx_busy), 32'd1);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(par);
`else
      if (par === 1'bz) $display("parity bit not sent");
`endif
      send_bit(stop);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_valid"}, 32'(n_valid), 32'(exp_valid));
      check({tag, "_ferr"}, 32'(n_ferr), 32'(exp_ferr));
      check({tag, "_perr"}, 32'(n_perr), 32'(exp_perr));
   endtask

   initial begin
      rx  = 1'b1;
      rst = 1'b1;
      cycles(3);
      check("rst_data", 32'(rx_data), 32'h00);
      check("rst_valid", 32'(rx_valid), 32'd0);
      check("rst_ferr", 32'(rx_frame_err), 32'd0);
      check("rst_perr", 32'(rx_parity_err), 32'd0);
      check("rst_busy", 32'(rx_busy), 32'd0);
      rst = 1'b0;
      cycles(5);

      // 4-tick low glitch: START entered, then aborted at mid bit.
      rx = 1'b0;
      cycles(4);
      check("glitch_busy", 32'(rx_busy), 32'd1);
      rx = 1'b1;
      cycles(30);
      check_counts("glitch");
      check("glitch_data", 32'(rx_data), 32'h00);
      check("glitch_idle", 32'(rx_busy), 32'd0);

      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      exp_valid++;
      check_counts("a5");
      check("a5_data", 32'(rx_data), 32'hA5);
      check("a5_busy", 32'(rx_busy), 32'd0);

      // Stop bit low: framing error; the still-low line retriggers a start that then aborts.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      rx = 1'b1;
      cycles(48);
      exp_ferr++;
      check_counts("ferr");
      check("ferr_data", 32'(rx_data), 32'hA5);
      check("ferr_busy", 32'(rx_busy), 32'd0);

      // Back-to-back frames, no idle gap.
      send_frame(8'h00, 1'b0, 1'b1, 1'b0);
      exp_valid++;
      check_counts("b2b0");
      check("b2b0_data", 32'(rx_data), 32'h00);
      send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
      exp_valid++;
      check_counts("b2b1");
      check("b2b1_data", 32'(rx_data), 32'hFF);

      // Reset in the middle of data bit 3 of 0x55.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rx = 1'b0;
      cycles(8 * tick_period);
      check("pre_rst_busy", 32'(rx_busy), 32'd1);
      rst = 1'b1;
      rx  = 1'b1;
      cycles(1);
      check("mid_rst_data", 32'(rx_data), 32'h00);
      check("mid_rst_busy", 32'(rx_busy), 32'd0);
      check("mid_rst_valid", 32'(rx_valid), 32'd0);
      cycles(2);
      rst = 1'b0;
      cycles(40);
      check_counts("abandon");
      send_frame(8'h81, 1'b0, 1'b1, 1'b0);
      exp_valid++;
      check_counts("post_rst");
      check("post_rst_data", 32'(rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b0, 1'b1, 1'b0);
      exp_perr++;
      check_counts("par_bad");
      check("par_bad_data", 32'(rx_data), 32'h81);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      exp_valid++;
      check_counts("par_good");
      check("par_good_data", 32'(rx_data), 32'h07);
`endif

      // One tick every third clock.
      tick_period = 3;
      cycles(10);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
      exp_valid++;
      check_counts("slow");
      check("slow_data", 32'(rx_data), 32'h5A);
      check("slow_busy", 32'(rx_busy), 32'd0);

      check("exclusive_pulses", 32'(n_multi), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
